// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared mode encoding and PWM constants for the LED sequencer.
package led_seq_pkg;
  localparam int MODE_W = 2;
  localparam int PWM_W = 8;
  localparam logic [PWM_W-1:0] DUTY_RESET = 8'd255;
  typedef enum logic [MODE_W-1:0] {
    HOLD   = 2'd0,
    ROT_L  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_e;
endpackage

// File: rtl/led_seq_prescaler.sv
// led_seq_prescaler: counts 0..div-1 and pulses tick on the wrap cycle; div of 0 acts as 1.
module led_seq_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic             restart,
  output logic             tick
);
  logic [DIV_W-1:0] r_cnt, w_last;
  assign w_last = (div == '0) ? '0 : div - DIV_W'(1);
  assign tick = (r_cnt == w_last);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= (tick || restart) ? '0 : r_cnt + DIV_W'(1);
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: tick-stepped LED pattern engine with valid/ready config loaded on a tick boundary.
// Define LED_PWM_EN to add the cfg_duty input and PWM dimming of led_o.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS    = 5,
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = 12000000,
  parameter int DEFAULT_PAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [NUM_LEDS-1:0] cfg_pat,
  input  logic [MODE_W-1:0]   cfg_mode,
  input  logic [DIV_W-1:0]    cfg_div,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0]    cfg_duty,
`endif
  output logic [NUM_LEDS-1:0] led_o,
  output logic                tick_o,
  output logic                dir_o
);
  localparam logic [NUM_LEDS-1:0] PAT_RST = NUM_LEDS'(DEFAULT_PAT);
  localparam logic [DIV_W-1:0]    DIV_RST = DIV_W'(DEFAULT_DIV);
  logic [NUM_LEDS-1:0] r_pat, r_pend_pat, w_pat_nxt;
  logic [DIV_W-1:0]    r_div, r_pend_div;
  mode_e               r_mode, r_pend_mode;
  logic                r_dir, r_pending, w_tick, w_cap, w_load, w_dir_nxt, w_left, w_on;
  assign cfg_ready = ~r_pending;
  assign dir_o = r_dir;
  assign w_cap = cfg_valid & ~r_pending;
  // a capture coinciding with a tick leaves r_pending low on that tick, so it waits for the next one
  assign w_load = w_tick & r_pending;
  assign w_left = r_dir ^ (r_dir ? r_pat[NUM_LEDS-1] : r_pat[0]);

  led_seq_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .div     (r_div),
    .restart (w_load),
    .tick    (w_tick)
  );

  always_comb begin
    w_pat_nxt = r_pat;
    w_dir_nxt = r_dir;
    if (w_load) begin
      w_pat_nxt = r_pend_pat;
      w_dir_nxt = 1'b1;
    end else if (w_tick) begin
      case (r_mode)
        ROT_L:   w_pat_nxt = {r_pat[NUM_LEDS-2:0], r_pat[NUM_LEDS-1]};
        BOUNCE: begin
          w_pat_nxt = w_left ? r_pat << 1 : r_pat >> 1;
          w_dir_nxt = w_left;
        end
        BLINK:   w_pat_nxt = ~r_pat;
        default: w_pat_nxt = r_pat;
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] r_pwm_cnt, r_duty, r_pend_duty, w_duty_nxt;
  assign w_duty_nxt = w_load ? r_pend_duty : r_duty;
  assign w_on = (r_pwm_cnt < w_duty_nxt);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pwm_cnt   <= '0;
      r_duty      <= DUTY_RESET;
      r_pend_duty <= DUTY_RESET;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      r_duty    <= w_duty_nxt;
      if (w_cap) r_pend_duty <= cfg_duty;
    end
`else
  assign w_on = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pat       <= PAT_RST;
      r_dir       <= 1'b1;
      r_mode      <= ROT_L;
      r_div       <= DIV_RST;
      r_pending   <= 1'b0;
      r_pend_pat  <= '0;
      r_pend_mode <= HOLD;
      r_pend_div  <= '0;
      led_o       <= PAT_RST;
      tick_o      <= 1'b0;
    end else begin
      r_pat  <= w_pat_nxt;
      r_dir  <= w_dir_nxt;
      led_o  <= w_pat_nxt & {NUM_LEDS{w_on}};
      tick_o <= w_tick;
      if (w_cap) begin
        r_pending   <= 1'b1;
        r_pend_pat  <= cfg_pat;
        r_pend_mode <= mode_e'(cfg_mode);
        r_pend_div  <= cfg_div;
      end else if (w_load) begin
        r_pending <= 1'b0;
        r_mode    <= r_pend_mode;
        r_div     <= r_pend_div;
      end
    end
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed vector table plus hand sequences for tick/capture collision and async reset.
module tb_led_sequencer;
  import led_seq_pkg::*;
  logic       clk, rst_n, cfg_valid, cfg_ready, tick_o, dir_o;
  logic [4:0] cfg_pat, led_o;
  logic [1:0] cfg_mode;
  logic [3:0] cfg_div;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         n;
    logic       v;
    logic [4:0] p;
    logic [1:0] m;
    logic [3:0] d;
    logic [4:0] led;
    logic       t;
    logic       dir;
    logic       rdy;
  } vec_t;
  vec_t tv[$];

  led_sequencer #(.NUM_LEDS(5), .DIV_W(4), .DEFAULT_DIV(4), .DEFAULT_PAT(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_pat   (cfg_pat),
    .cfg_mode  (cfg_mode),
    .cfg_div   (cfg_div),
`ifdef LED_PWM_EN
    .cfg_duty  (8'd255),
`endif
    .led_o     (led_o),
    .tick_o    (tick_o),
    .dir_o     (dir_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [4:0] led, input logic t,
                     input logic d, input logic r);
    checks += 4;
    if (led_o !== led) begin
      errors++;
      $display("FAIL %s[%0d] led_o got %b expected %b", nm, idx, led_o, led);
    end
    if (tick_o !== t) begin
      errors++;
      $display("FAIL %s[%0d] tick_o got %b expected %b", nm, idx, tick_o, t);
    end
    if (dir_o !== d) begin
      errors++;
      $display("FAIL %s[%0d] dir_o got %b expected %b", nm, idx, dir_o, d);
    end
    if (cfg_ready !== r) begin
      errors++;
      $display("FAIL %s[%0d] cfg_ready got %b expected %b", nm, idx, cfg_ready, r);
    end
  endtask

  task automatic run(input int n, input logic v, input logic [4:0] p, input logic [1:0] m,
                     input logic [3:0] d);
    cfg_valid = v;
    cfg_pat   = p;
    cfg_mode  = m;
    cfg_div   = d;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // each row: edges to advance with these inputs, then expected outputs
    tv.push_back('{3, 1'b0, 5'b00000, HOLD,   4'd0, 5'b00001, 1'b0, 1'b1, 1'b1});
    tv.push_back('{1, 1'b0, 5'b00000, HOLD,   4'd0, 5'b00010, 1'b1, 1'b1, 1'b1});
    tv.push_back('{1, 1'b0, 5'b00000, HOLD,   4'd0, 5'b00010, 1'b0, 1'b1, 1'b1});
    tv.push_back('{3, 1'b0, 5'b00000, HOLD,   4'd0, 5'b00100, 1'b1, 1'b1, 1'b1});
    tv.push_back('{4, 1'b0, 5'b00000, HOLD,   4'd0, 5'b01000, 1'b1, 1'b1, 1'b1});
    tv.push_back('{3, 1'b0, 5'b00000, HOLD,   4'd0, 5'b01000, 1'b0, 1'b1, 1'b1});
    tv.push_back('{1, 1'b0, 5'b00000, HOLD,   4'd0, 5'b10000, 1'b1, 1'b1, 1'b1});
    tv.push_back('{4, 1'b0, 5'b00000, HOLD,   4'd0, 5'b00001, 1'b1, 1'b1, 1'b1});
    tv.push_back('{1, 1'b1, 5'b00001, BOUNCE, 4'd2, 5'b00001, 1'b0, 1'b1, 1'b0});
    tv.push_back('{2, 1'b0, 5'b00000, HOLD,   4'd0, 5'b00001, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1, 1'b0, 5'b00000, HOLD,   4'd0, 5'b00001, 1'b1, 1'b1, 1'b1});
    tv.push_back('{2, 1'b0, 5'b00000, HOLD,   4'd0, 5'b00010, 1'b1, 1'b1, 1'b1});
    tv.push_back('{2, 1'b0, 5'b00000, HOLD,   4'd0, 5'b00100, 1'b1, 1'b1, 1'b1});
    tv.push_back('{2, 1'b0, 5'b00000, HOLD,   4'd0, 5'b01000, 1'b1, 1'b1, 1'b1});
    tv.push_back('{2, 1'b0, 5'b00000, HOLD,   4'd0, 5'b10000, 1'b1, 1'b1, 1'b1});
    tv.push_back('{1, 1'b0, 5'b00000, HOLD,   4'd0, 5'b10000, 1'b0, 1'b1, 1'b1});
    tv.push_back('{1, 1'b0, 5'b00000, HOLD,   4'd0, 5'b01000, 1'b1, 1'b0, 1'b1});
    tv.push_back('{2, 1'b0, 5'b00000, HOLD,   4'd0, 5'b00100, 1'b1, 1'b0, 1'b1});
    tv.push_back('{2, 1'b0, 5'b00000, HOLD,   4'd0, 5'b00010, 1'b1, 1'b0, 1'b1});
    tv.push_back('{2, 1'b0, 5'b00000, HOLD,   4'd0, 5'b00001, 1'b1, 1'b0, 1'b1});
    tv.push_back('{2, 1'b0, 5'b00000, HOLD,   4'd0, 5'b00010, 1'b1, 1'b1, 1'b1});

    rst_n = 1'b1;
    cfg_valid = 1'b0;
    cfg_pat = '0;
    cfg_mode = '0;
    cfg_div = '0;
    #1 rst_n = 1'b0;
    #1 chk("reset", 0, 5'b00001, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1 chk("reset", 1, 5'b00001, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      run(tv[i].n, tv[i].v, tv[i].p, tv[i].m, tv[i].d);
      chk("vec", i, tv[i].led, tv[i].t, tv[i].dir, tv[i].rdy);
    end

    // offer config in the same cycle as a bounce tick: it must wait for the following tick
    run(1, 1'b0, 5'b00000, HOLD, 4'd0);
    chk("collide", 0, 5'b00010, 1'b0, 1'b1, 1'b1);
    run(1, 1'b1, 5'b10101, BLINK, 4'd0);
    chk("collide", 1, 5'b00100, 1'b1, 1'b1, 1'b0);
    run(1, 1'b0, 5'b00000, HOLD, 4'd0);
    chk("collide", 2, 5'b00100, 1'b0, 1'b1, 1'b0);
    run(1, 1'b0, 5'b00000, HOLD, 4'd0);
    chk("collide", 3, 5'b10101, 1'b1, 1'b1, 1'b1);
    run(1, 1'b0, 5'b00000, HOLD, 4'd0);
    chk("blink", 0, 5'b01010, 1'b1, 1'b1, 1'b1);
    run(1, 1'b0, 5'b00000, HOLD, 4'd0);
    chk("blink", 1, 5'b10101, 1'b1, 1'b1, 1'b1);

    // async reset while a HOLD 11111 config is pending; it must never appear
    run(1, 1'b1, 5'b11111, HOLD, 4'd5);
    chk("pend", 0, 5'b01010, 1'b1, 1'b1, 1'b0);
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1 chk("async_rst", 0, 5'b00001, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1 chk("async_rst", 1, 5'b00001, 1'b0, 1'b1, 1'b1);
    rst_n = 1'b1;
    run(3, 1'b0, 5'b00000, HOLD, 4'd0);
    chk("no_stale", 0, 5'b00001, 1'b0, 1'b1, 1'b1);
    run(1, 1'b0, 5'b00000, HOLD, 4'd0);
    chk("no_stale", 1, 5'b00010, 1'b1, 1'b1, 1'b1);
    run(4, 1'b0, 5'b00000, HOLD, 4'd0);
    chk("no_stale", 2, 5'b00100, 1'b1, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
